// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath (R-type, addi, lw, sw, beq, j).
// Control outputs are decoded from the current state and the memory handshake; the retired-instruction count is registered.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       Op_i,
  input  logic             MemReady_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic [1:0]       PCSource_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic             RegWrite_o,
  output logic             RegDst_o,
  output logic             InstDone_o,
  output logic             Illegal_o,
  output logic [CNT_W-1:0] InstCount_o,
  output logic [3:0]       State_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // State and retired-instruction counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = S_FETCH;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    PCSource_o    = 2'b00;
    ALUOp_o       = 2'b00;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    RegWrite_o    = 1'b0;
    RegDst_o      = 1'b0;
    InstDone_o    = 1'b0;
    Illegal_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = MemReady_i;
        PCWrite_o = MemReady_i;
        state_d   = MemReady_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            Illegal_o = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        // Opcode is stable from the IR; anything else here is abandoned
        if (Op_i == OP_LW)      state_d = S_MEM_READ;
        else if (Op_i == OP_SW) state_d = S_MEM_WRITE;
        else                    state_d = S_FETCH;
      end
      S_MEM_READ: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        state_d   = MemReady_i ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        InstDone_o = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        InstDone_o = MemReady_i;
        state_d    = MemReady_i ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        InstDone_o = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o = 1'b1;
        InstDone_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        InstDone_o    = 1'b1;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
        InstDone_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every enable so an abandoned instruction writes nothing
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      PCSource_o    = 2'b00;
      ALUOp_o       = 2'b00;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      InstDone_o    = 1'b0;
      Illegal_o     = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (InstDone_o) count_d = count_q + CNT_W'(1);
  end

  assign InstCount_o = count_q;
  assign State_o     = rst_i ? 4'd0 : 4'(state_q);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multicycle MIPS datapath: shared ALU, single unified memory, instruction register, PC.
- Supports R-type, addi, lw, sw, beq and j, with a ready handshake on the unified memory.
- Drives all datapath mux selects and write enables.
- Reports per-instruction retirement and a retired-instruction count.

Parameters:
- CNT_W, 32, width of the retired-instruction counter InstCount_o.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- Op_i  input  6  opcode from IR[31:26]; valid from DECODE onward.
- MemReady_i  input  1  memory has completed the current read or write in this cycle.
- PCWrite_o  output  1  unconditional PC load.
- PCWriteCond_o  output  1  PC load if ALU zero (beq).
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead_o  output  1  memory read request.
- MemWrite_o  output  1  memory write request.
- IRWrite_o  output  1  instruction register load.
- MemtoReg_o  output  1  register write data: 0 = ALUOut, 1 = MDR.
- PCSource_o  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp_o  output  2  00 = add, 01 = sub, 10 = use funct.
- ALUSrcA_o  output  1  0 = PC, 1 = register A.
- ALUSrcB_o  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- RegWrite_o  output  1  register file write.
- RegDst_o  output  1  destination register: 0 = rt, 1 = rd.
- InstDone_o  output  1  one-cycle pulse in the final cycle of each retired instruction.
- Illegal_o  output  1  one-cycle pulse in DECODE on an unsupported opcode.
- InstCount_o  output  CNT_W  count of retired instructions.
- State_o  output  4  current state encoding, for debug.

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXEC_R = 6, R_WB = 7, BRANCH = 8, JUMP = 9, EXEC_I = 10, I_WB = 11
  - Codes 12–15 are unused; any unused code goes to FETCH on the next edge.
- Reset:
  - rst_i high at an edge sets state to FETCH, InstCount_o to 0 and clears all registered pulses.
  - While rst_i is high, every control output, InstDone_o and Illegal_o is forced to 0.
  - State_o reads 0 during reset.
  - Reset mid-instruction abandons it; no write enable is asserted in that cycle.
- Outputs are not listed per state are 0. All outputs are combinational decodes of state, plus the MemReady_i and Op_i terms noted.
- FETCH:
  - Outputs: MemRead_o = 1, IorD_o = 0, ALUSrcA_o = 0, ALUSrcB_o = 01, ALUOp_o = 00, PCSource_o = 00.
  - IRWrite_o = PCWrite_o = MemReady_i.
  - Stay in FETCH while MemReady_i = 0; go to DECODE when it is 1.
- DECODE:
  - Outputs: ALUSrcA_o = 0, ALUSrcB_o = 11, ALUOp_o = 00 (branch target computed into ALUOut).
  - Next state by Op_i:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 (R-type) -> EXEC_R
    - 001000 (addi) -> EXEC_I
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with Illegal_o = 1 this cycle.
- MEM_ADDR:
  - Outputs: ALUSrcA_o = 1, ALUSrcB_o = 10, ALUOp_o = 00.
  - Next: MEM_READ if Op_i is lw, MEM_WRITE if Op_i is sw.
- MEM_READ:
  - Outputs: MemRead_o = 1, IorD_o = 1.
  - Wait while MemReady_i = 0; go to MEM_WB when it is 1.
- MEM_WB:
  - Outputs: RegWrite_o = 1, MemtoReg_o = 1, RegDst_o = 0, InstDone_o = 1.
  - Next: FETCH.
- MEM_WRITE:
  - Outputs: MemWrite_o = 1, IorD_o = 1, InstDone_o = MemReady_i.
  - Wait while MemReady_i = 0; go to FETCH when it is 1.
- EXEC_R: ALUSrcA_o = 1, ALUSrcB_o = 00, ALUOp_o = 10; next R_WB.
- R_WB: RegWrite_o = 1, RegDst_o = 1, MemtoReg_o = 0, InstDone_o = 1; next FETCH.
- EXEC_I: ALUSrcA_o = 1, ALUSrcB_o = 10, ALUOp_o = 00; next I_WB.
- I_WB: RegWrite_o = 1, RegDst_o = 0, MemtoReg_o = 0, InstDone_o = 1; next FETCH.
- BRANCH: ALUSrcA_o = 1, ALUSrcB_o = 00, ALUOp_o = 01, PCWriteCond_o = 1, PCSource_o = 01, InstDone_o = 1; next FETCH.
- JUMP: PCWrite_o = 1, PCSource_o = 10, InstDone_o = 1; next FETCH.
- Latency, assuming MemReady_i is high on first request:
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
  - Each memory wait cycle adds 1.
- InstCount_o:
  - Increments by 1 on each edge where InstDone_o = 1.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes do not count.
- Invariants:
  - MemRead_o and MemWrite_o are never both 1.
  - RegWrite_o is never 1 in a waiting memory state.

Test Plan:
- Reset: rst_i = 1 for 2 cycles, then low -> during reset all outputs 0 and State_o = 0; first cycle after reset State_o = 0, MemRead_o = 1, IorD_o = 0.
- R-type, MemReady_i tied 1: Op_i = 000000 -> states 0, 1, 6, 7; RegWrite_o = 1 and RegDst_o = 1 in state 7; InstDone_o pulses once; InstCount_o goes 0 -> 1.
- lw with memory waits: MemReady_i held 0 for 3 cycles in FETCH and 2 in MEM_READ -> IRWrite_o asserted only in the ready cycle; total 10 cycles; MemtoReg_o = 1 in MEM_WB.
- beq and j back-to-back: beq -> BRANCH with PCWriteCond_o = 1, PCSource_o = 01; j -> JUMP with PCWrite_o = 1, PCSource_o = 10; each takes 3 cycles; InstCount_o increases by 2.
- Illegal opcode: Op_i = 111111 in DECODE -> Illegal_o = 1 for 1 cycle, next state FETCH, InstCount_o unchanged, no write enables asserted.
- Reset mid-sw: rst_i asserted in MEM_WRITE while MemReady_i = 0 -> MemWrite_o = 0 that cycle, State_o = 0 next, InstCount_o = 0; counter wrap with CNT_W = 4 after 16 instructions -> InstCount_o = 0.
